// File: rtl/pio_pkg.sv
// pio_pkg: register map and edge-type encoding shared by the PIO block.
package pio_pkg;
  localparam logic [2:0] PIO_REG_DATA    = 3'd0;
  localparam logic [2:0] PIO_REG_DIR     = 3'd1;
  localparam logic [2:0] PIO_REG_IRQMASK = 3'd2;
  localparam logic [2:0] PIO_REG_EDGECAP = 3'd3;
  localparam logic [2:0] PIO_REG_OUTSET  = 3'd4;
  localparam logic [2:0] PIO_REG_OUTCLR  = 3'd5;
  typedef enum logic [1:0] {EDGE_RISE, EDGE_FALL, EDGE_ANY} edge_t;
endpackage

// File: rtl/pio_debounce.sv
// pio_debounce: one-bit debouncer; accepts a new level only after it has held
// for CYCLES consecutive cycles.
module pio_debounce #(
  parameter int CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);
  localparam int CW = $clog2(CYCLES);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (din == dout) cnt <= '0;
    else if (cnt == CW'(CYCLES - 1)) begin
      cnt  <= '0;
      dout <= din;
    end else cnt <= cnt + 1'b1;
endmodule

// File: rtl/pio_edge_irq.sv
// pio_edge_irq: Avalon-MM PIO with direction, edge capture, masked level irq
// and atomic output set/clear. Define PIO_DEBOUNCE_EN to debounce the inputs.
module pio_edge_irq
  import pio_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               EDGE_TYPE       = 0,
  parameter logic [WIDTH-1:0] RESET_OUT       = '0,
  parameter logic [WIDTH-1:0] RESET_DIR       = '0,
  parameter int               DEBOUNCE_CYCLES = 16
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [2:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  input  logic [WIDTH-1:0] pio_in,
  output logic [WIDTH-1:0] pio_out,
  output logic [WIDTH-1:0] pio_oe,
  output logic             irq
);
  logic [WIDTH-1:0] s1, s2, in_q, in_d, ev, cap, mask, wd, clr;
  logic [31:0] rdata;
  logic unused_hi;
  assign wd = avs_writedata[WIDTH-1:0];
  assign unused_hi = ^avs_writedata;
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_db
    $error("DEBOUNCE_CYCLES must be >= 2");
  end
`ifdef PIO_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    pio_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk  (clk_clk),
      .rst_n(reset_reset_n),
      .din  (s2[i]),
      .dout (in_q[i])
    );
  end
`else
  assign in_q = s2;
`endif
  always_comb begin
    ev = EDGE_TYPE == int'(EDGE_FALL) ? ~in_q & in_d :
         EDGE_TYPE == int'(EDGE_ANY)  ? in_q ^ in_d  : in_q & ~in_d;
    clr = (avs_write && avs_address == PIO_REG_EDGECAP) ? wd : '0;
    rdata = avs_address == PIO_REG_DATA    ? 32'(in_q)   :
            avs_address == PIO_REG_DIR     ? 32'(pio_oe) :
            avs_address == PIO_REG_IRQMASK ? 32'(mask)   :
            avs_address == PIO_REG_EDGECAP ? 32'(cap)    : '0;
  end
  // Capture sets win over a same-cycle W1C; reads see pre-write state.
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) begin
      s1           <= '0;
      s2           <= '0;
      in_d         <= '0;
      cap          <= '0;
      mask         <= '0;
      pio_out      <= RESET_OUT;
      pio_oe       <= RESET_DIR;
      avs_readdata <= '0;
      irq          <= 1'b0;
    end else begin
      s1   <= pio_in;
      s2   <= s1;
      in_d <= in_q;
      cap  <= (cap & ~clr) | ev;
      irq  <= |(cap & mask);
      if (avs_read) avs_readdata <= rdata;
      if (avs_write) begin
        if (avs_address == PIO_REG_DATA)    pio_out <= wd;
        if (avs_address == PIO_REG_OUTSET)  pio_out <= pio_out | wd;
        if (avs_address == PIO_REG_OUTCLR)  pio_out <= pio_out & ~wd;
        if (avs_address == PIO_REG_DIR)     pio_oe  <= wd;
        if (avs_address == PIO_REG_IRQMASK) mask    <= wd;
      end
    end
endmodule

// File: tb/tb_pio_edge_irq.sv
// tb_pio_edge_irq: scoreboard bench with a rising-edge and a falling-edge PIO
// sharing one Avalon bus. Define PIO_DEBOUNCE_EN to exercise the debouncer.
module tb_pio_edge_irq;
  import pio_pkg::*;
`ifdef PIO_DEBOUNCE_EN
  localparam int LAT = 19;
`else
  localparam int LAT = 3;
`endif
  typedef struct {string name; int sel; logic [31:0] val;} exp_t;
  logic clk, rst_n, rd, wr, rv;
  logic [2:0] addr;
  logic [31:0] wdata, rdata0, rdata1;
  logic [3:0] pin0, pin1, out0, out1, oe0, oe1;
  logic irq0, irq1;
  exp_t rq[$], pq[$];
  int checks = 0, errors = 0;

  pio_edge_irq #(.WIDTH(4), .EDGE_TYPE(0), .RESET_OUT(4'hA), .RESET_DIR(4'hF), .DEBOUNCE_CYCLES(16)) dut0 (
    .clk_clk(clk), .reset_reset_n(rst_n), .avs_address(addr), .avs_read(rd), .avs_write(wr),
    .avs_writedata(wdata), .avs_readdata(rdata0), .pio_in(pin0), .pio_out(out0), .pio_oe(oe0), .irq(irq0));
  pio_edge_irq #(.WIDTH(4), .EDGE_TYPE(1), .RESET_OUT(4'h0), .RESET_DIR(4'h0), .DEBOUNCE_CYCLES(16)) dut1 (
    .clk_clk(clk), .reset_reset_n(rst_n), .avs_address(addr), .avs_read(rd), .avs_write(wr),
    .avs_writedata(wdata), .avs_readdata(rdata1), .pio_in(pin1), .pio_out(out1), .pio_oe(oe1), .irq(irq1));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) rv <= rd;

  function automatic logic [31:0] probe(int sel);
    case (sel)
      0: return rdata0;
      1: return rdata1;
      2: return 32'(out0);
      3: return 32'(oe0);
      4: return 32'(irq0);
      default: return 32'(irq1);
    endcase
  endfunction

  task automatic compare(exp_t e);
    checks++;
    if (probe(e.sel) !== e.val) begin
      errors++;
      $display("FAIL %s: got %h expected %h", e.name, probe(e.sel), e.val);
    end
  endtask

  // Monitor: read data is due the cycle after a read strobe; peeks are due now.
  always @(negedge clk) begin
    if (rv) begin
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: got %h expected no read", rdata0);
      end else compare(rq.pop_front());
    end
    while (pq.size() > 0) compare(pq.pop_front());
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr_reg(logic [2:0] a, logic [31:0] d);
    addr = a; wdata = d; wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask
  task automatic rd_reg(string name, logic [2:0] a, int sel, logic [31:0] v);
    addr = a; rd = 1'b1;
    rq.push_back('{name, sel, v});
    tick();
    rd = 1'b0;
  endtask
  task automatic rw_reg(string name, logic [2:0] a, logic [31:0] d, int sel, logic [31:0] v);
    addr = a; wdata = d; rd = 1'b1; wr = 1'b1;
    rq.push_back('{name, sel, v});
    tick();
    rd = 1'b0; wr = 1'b0;
  endtask
  task automatic peek(string name, int sel, logic [31:0] v);
    pq.push_back('{name, sel, v});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; pin0 = 4'h0; pin1 = 4'hF;
    repeat (3) tick();
    peek("rst_out", 2, 32'hA);
    peek("rst_oe", 3, 32'hF);
    peek("rst_irq", 4, 32'h0);
    peek("rst_rdata", 0, 32'h0);
    tick();
    rst_n = 1'b1;
    repeat (LAT + 3) tick();
    rd_reg("rst_cap0", PIO_REG_EDGECAP, 0, 32'h0);
    rd_reg("rst_cap1", PIO_REG_EDGECAP, 1, 32'h0);
    // Output register, set and clear
    wr_reg(PIO_REG_DATA, 32'h5);   peek("out_data", 2, 32'h5);
    wr_reg(PIO_REG_OUTSET, 32'h2); peek("out_set", 2, 32'h7);
    wr_reg(PIO_REG_OUTCLR, 32'h4); peek("out_clr", 2, 32'h3);
    rd_reg("rd_outset", PIO_REG_OUTSET, 0, 32'h0);
    rd_reg("rd_outclr", PIO_REG_OUTCLR, 0, 32'h0);
    wr_reg(3'd6, 32'hFF);
    rd_reg("rd_rsvd6", 3'd6, 0, 32'h0);
    rd_reg("rd_rsvd7", 3'd7, 0, 32'h0);
    wr_reg(PIO_REG_DIR, 32'h3);
    rd_reg("rd_dir", PIO_REG_DIR, 0, 32'h3);
    rw_reg("rw_dir_old", PIO_REG_DIR, 32'h5, 0, 32'h3);
    rd_reg("rd_dir_new", PIO_REG_DIR, 0, 32'h5);
    peek("oe_new", 3, 32'h5);
    wr_reg(PIO_REG_DATA, 32'hFFFF_FFF0); peek("out_hi_ignored", 2, 32'h0);
    // Rising edge with interrupt
    wr_reg(PIO_REG_IRQMASK, 32'h1);
    pin0[0] = 1'b1;
    repeat (LAT) tick();
    peek("irq_lag", 4, 32'h0);
    rd_reg("cap_rise", PIO_REG_EDGECAP, 0, 32'h1);
    peek("irq_rise", 4, 32'h1);
    rd_reg("data_in", PIO_REG_DATA, 0, 32'h1);
    wr_reg(PIO_REG_EDGECAP, 32'h1); peek("irq_hold", 4, 32'h1);
    tick();                         peek("irq_clr", 4, 32'h0);
    // Edge coincident with W1C of the same bit
    pin0[2] = 1'b1;
    repeat (LAT - 1) tick();
    wr_reg(PIO_REG_EDGECAP, 32'h4);
    rd_reg("cap_set_wins", PIO_REG_EDGECAP, 0, 32'h4);
    peek("irq_unmasked_bit", 4, 32'h0);
    wr_reg(PIO_REG_EDGECAP, 32'h4);
    rd_reg("cap_w1c", PIO_REG_EDGECAP, 0, 32'h0);
    // Masked falling edge on the falling-edge instance
    wr_reg(PIO_REG_IRQMASK, 32'h0);
    pin1[3] = 1'b0;
    repeat (LAT) tick();
    rd_reg("cap_fall", PIO_REG_EDGECAP, 1, 32'h8);
    peek("irq_masked", 5, 32'h0);
    wr_reg(PIO_REG_IRQMASK, 32'h8); peek("irq_mask_lag", 5, 32'h0);
    tick();                         peek("irq_unmask", 5, 32'h1);
    peek("irq0_quiet", 4, 32'h0);
    // Opposite edges must not capture
    pin0[0] = 1'b0;
    pin1[3] = 1'b1;
    repeat (LAT + 2) tick();
    rd_reg("no_fall_cap0", PIO_REG_EDGECAP, 0, 32'h0);
    rd_reg("no_rise_cap1", PIO_REG_EDGECAP, 1, 32'h8);
    rd_reg("data1", PIO_REG_DATA, 1, 32'hF);
`ifdef PIO_DEBOUNCE_EN
    pin0[0] = 1'b1;
    repeat (10) tick();
    pin0[0] = 1'b0;
    repeat (25) tick();
    rd_reg("db_short_data", PIO_REG_DATA, 0, 32'h4);
    rd_reg("db_short_cap", PIO_REG_EDGECAP, 0, 32'h0);
    pin0[0] = 1'b1;
    repeat (20) tick();
    rd_reg("db_long_data", PIO_REG_DATA, 0, 32'h5);
    rd_reg("db_long_cap", PIO_REG_EDGECAP, 0, 32'h1);
`endif
    repeat (3) tick();
    if (rq.size() != 0 || pq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", rq.size() + pq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pio_edge_irq.md
Name: pio_edge_irq

Overview:
Parametrised general-purpose PIO, the successor to the fixed button, dipsw and led PIOs in the FPGA fabric.
- Configurable width, per-bit direction, edge capture, masked level interrupt and atomic set/clear of outputs.
- Sits on the HPS lightweight bridge as an Avalon-MM slave with fixed read latency of 1.
- Drives board pins through pio_out/pio_oe and samples them through pio_in.

Parameters:
WIDTH, 4, number of PIO bits (1..32)
EDGE_TYPE, 0, edge detected for capture: 0 rising, 1 falling, 2 any
RESET_OUT, 0, reset value of output register (WIDTH bits)
RESET_DIR, 0, reset value of direction register (1 = output)
DEBOUNCE_CYCLES, 16, stable cycles required before an input change is accepted (debounce build only, >=2)

Ports:
clk_clk  in  1  system clock
reset_reset_n  in  1  asynchronous active-low reset
avs_address  in  3  word register index
avs_read  in  1  read strobe
avs_write  in  1  write strobe
avs_writedata  in  32  write data; bits above WIDTH ignored
avs_readdata  out  32  read data, valid the cycle after avs_read; bits above WIDTH read 0
pio_in  in  WIDTH  asynchronous pin inputs
pio_out  out  WIDTH  output register value
pio_oe  out  WIDTH  output enable = direction register
irq  out  1  level interrupt

Behaviour:
- Reset (asynchronous, reset_reset_n low): pio_out=RESET_OUT, pio_oe=RESET_DIR, irqmask=0, edgecapture=0, synchroniser and debounce state=0, avs_readdata=0, irq=0.
- Input path: pio_in passes through a 2-flop synchroniser, then the debouncer (if built), giving in_q. in_d is in_q delayed by one cycle.
- Edge event per bit:
  - EDGE_TYPE 0: in_q & ~in_d
  - EDGE_TYPE 1: ~in_q & in_d
  - EDGE_TYPE 2: in_q ^ in_d
- Edges are detected regardless of direction.
- Pin-to-capture latency is 3 cycles without debounce.
- Register map (word address):
  - 0 DATA: read in_q; write loads pio_out.
  - 1 DIR: read/write.
  - 2 IRQMASK: read/write.
  - 3 EDGECAP: read; write-1-to-clear.
  - 4 OUTSET: write ORs into pio_out; reads 0.
  - 5 OUTCLR: write clears pio_out bits where data is 1; reads 0.
  - 6-7: reserved; read 0, writes ignored.
- Same-cycle edge event and W1C clear on one bit: set wins, bit stays 1.
- Read timing: registered; avs_readdata updates only on a cycle with avs_read and holds otherwise. A read of EDGECAP returns the value before any same-cycle write.
- avs_read and avs_write together: both performed; read returns the pre-write value.
- irq = |(edgecapture & irqmask), registered, so it rises 1 cycle after the capture bit sets.
- Writes never stall; there is no waitrequest.

Optional Feature:
- Macro PIO_DEBOUNCE_EN.
- Defined: each bit has a counter of width clog2(DEBOUNCE_CYCLES).
  - When the synchronised input differs from the accepted value, the counter increments. On reaching DEBOUNCE_CYCLES-1 the accepted value flips and the counter clears.
  - Any cycle where the input equals the accepted value clears the counter, so glitches shorter than DEBOUNCE_CYCLES are rejected.
  - Latency = 2 + DEBOUNCE_CYCLES + 1 cycles.
- Undefined: no debounce logic; in_q equals the synchronised value.

Decomposition:
- Package pio_pkg: register address constants (PIO_REG_DATA..PIO_REG_OUTCLR) and edge-type enum (EDGE_RISE, EDGE_FALL, EDGE_ANY).
- One sub-module, pio_debounce, holds the per-bit counter and accepted value. It is instantiated WIDTH times under PIO_DEBOUNCE_EN.

Test Plan:
- Reset values: reset with RESET_OUT=4'hA, RESET_DIR=4'hF -> pio_out=A, pio_oe=F, irq=0, read addr 3 -> 0.
- Output set/clear: write DATA=4'h5, OUTSET=4'h2, OUTCLR=4'h4 -> pio_out 5, then 7, then 3. Reads of addr 4/5 -> 0.
- Rising edge with interrupt: EDGE_TYPE 0, IRQMASK=4'h1, pio_in bit0 0->1 -> EDGECAP=1 at cycle+3, irq=1 at cycle+4. Write EDGECAP=1 -> irq=0 two cycles later.
- Set-wins collision: edge on bit2 coincident with EDGECAP write 4'h4 -> EDGECAP bit2 stays 1.
- Masked edge: falling edge on bit3 with IRQMASK=0 (EDGE_TYPE 1) -> EDGECAP=8, irq stays 0. Then set mask=8 -> irq=1.
- Debounce (PIO_DEBOUNCE_EN, DEBOUNCE_CYCLES=16): 10-cycle pulse on bit0 -> DATA stays 0, no capture. 20-cycle pulse -> DATA bit0=1 and EDGECAP bit0=1.
